// File: rtl/instr_mem_loadable.sv
// Instruction memory for the fetch stage. Fetch is word-aligned and registered.
// A byte-serial port loads a program into the array, MSB first.
// Loading stops on a HALT word (all ones) or when the array is full.
module instr_mem_loadable #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 64,
  parameter int NB_CNT = $clog2(CELDAS + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NBITS-1:0]  i_PC,
  input  logic              i_enable,
  output logic [NBITS-1:0]  o_Instruction,
  output logic              o_invalid,
  output logic              o_busy,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic [NB_CNT-1:0] o_load_count
);

  localparam int BPW   = NBITS / 8;
  localparam int AW    = (CELDAS > 1) ? $clog2(CELDAS) : 1;
  localparam int NB_BC = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Contents are not touched by reset. Power-up zero comes from the device
  // configuration, not from any reset logic.
  logic [NBITS-1:0]  mem [CELDAS];

  logic [1:0]        state_q, state_d;
  logic [NB_CNT-1:0] ptr_q, ptr_d;
  logic [NB_BC-1:0]  bcnt_q, bcnt_d;
  logic [NBITS-1:0]  asm_q, asm_d;
  logic [NBITS-1:0]  instr_q, instr_d;
  logic              invalid_q, invalid_d;

  logic              busy;
  logic              accept;
  logic              fetch_ok;
  logic [NBITS-1:0]  word_idx;
  logic [NB_CNT-1:0] ptr_next;

  assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign accept   = (state_q == S_LOAD) && i_load_valid;
  assign word_idx = i_PC >> 2;
  assign fetch_ok = (i_PC[1:0] == 2'b00) && (word_idx < NBITS'(CELDAS));
  assign ptr_next = ptr_q + NB_CNT'(1);

  // Load FSM: byte assembly, word write and termination on HALT or full.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          asm_d = (asm_q << 8) | NBITS'(i_load_byte);
          if (bcnt_q == NB_BC'(BPW - 1)) begin
            state_d = S_WRITE;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bcnt_q + NB_BC'(1);
          end
        end
      end
      S_WRITE: begin
        ptr_d = ptr_next;
        if ((asm_q == {NBITS{1'b1}}) || (ptr_next == NB_CNT'(CELDAS))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          bcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch path: NOP while loading, hold on stall, NOP plus flag on a bad address.
  always_comb begin
    instr_d   = instr_q;
    invalid_d = invalid_q;
    if (busy) begin
      instr_d   = '0;
      invalid_d = 1'b0;
    end else if (i_enable) begin
      if (fetch_ok) begin
        instr_d   = mem[word_idx[AW-1:0]];
        invalid_d = 1'b0;
      end else begin
        instr_d   = '0;
        invalid_d = 1'b1;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      bcnt_q    <= '0;
      instr_q   <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      bcnt_q    <= bcnt_d;
      instr_q   <= instr_d;
      invalid_q <= invalid_d;
    end
  end

  // Assembly register; a partial word is simply abandoned on reset.
  always_ff @(posedge i_clk) begin
    asm_q <= asm_d;
  end

  // Array write during the single WRITE cycle.
  always_ff @(posedge i_clk) begin
    if (state_q == S_WRITE) begin
      mem[ptr_q[AW-1:0]] <= asm_q;
    end
  end

  assign o_Instruction = instr_q;
  assign o_invalid     = invalid_q;
  assign o_busy        = busy;
  assign o_load_ready  = (state_q == S_LOAD);
  assign o_load_done   = (state_q == S_DONE);
  assign o_load_count  = ptr_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: fetch, load, stall, bounds, reset mid-load.
module tb_instr_mem_loadable;

  localparam int NBITS  = 32;
  localparam int CELDAS = 16;
  localparam int NBC    = $clog2(CELDAS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NBITS-1:0] pc;
  logic             en;
  logic [NBITS-1:0] instr;
  logic             inv;
  logic             busy;
  logic             start;
  logic             lvalid;
  logic [7:0]       lbyte;
  logic             lready;
  logic             ldone;
  logic [NBC-1:0]   lcount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_mem_loadable #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_PC          (pc),
    .i_enable      (en),
    .o_Instruction (instr),
    .o_invalid     (inv),
    .o_busy        (busy),
    .i_load_start  (start),
    .i_load_valid  (lvalid),
    .i_load_byte   (lbyte),
    .o_load_ready  (lready),
    .o_load_done   (ldone),
    .o_load_count  (lcount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!lready && n < 20) begin
      tick();
      n++;
    end
    if (!lready) chk("ready_wait", 32'(lready), 32'd1);
    lvalid = 1'b1;
    lbyte  = b;
    tick();
    lvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!ldone && n < 20) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(ldone), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; en = 1'b0; start = 1'b0; lvalid = 1'b0; lbyte = '0;
    #12;
    chk("rst_instr", instr, 32'h0);
    chk("rst_invalid", 32'(inv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(lready), 32'd0);
    chk("rst_done", 32'(ldone), 32'd0);
    chk("rst_count", 32'(lcount), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero array fetches
    en = 1'b1;
    fetch(0);  chk("zero_pc0", instr, 32'h0); chk("zero_pc0_inv", 32'(inv), 32'd0);
    fetch(4);  chk("zero_pc4", instr, 32'h0);
    fetch(8);  chk("zero_pc8", instr, 32'h0); chk("zero_pc8_inv", 32'(inv), 32'd0);

    // Load one word plus HALT
    pulse_start();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(lready), 32'd1);
    chk("load_count0", 32'(lcount), 32'd0);
    pc = 0;
    send_byte(8'h20);
    chk("busy_instr", instr, 32'h0);
    chk("busy_inv", 32'(inv), 32'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("load1_count", 32'(lcount), 32'd2);
    chk("load1_busy", 32'(busy), 32'd0);
    fetch(0); chk("load1_pc0", instr, 32'h2001_0002); chk("load1_pc0_inv", 32'(inv), 32'd0);
    fetch(4); chk("load1_pc4", instr, 32'hFFFF_FFFF);

    // Invalid addresses and last valid word
    fetch(6);          chk("mis_instr", instr, 32'h0); chk("mis_inv", 32'(inv), 32'd1);
    fetch(4 * CELDAS); chk("oor_instr", instr, 32'h0); chk("oor_inv", 32'(inv), 32'd1);
    fetch(4 * CELDAS - 4); chk("last_inv", 32'(inv), 32'd0); chk("last_instr", instr, 32'h0);

    // Stall holds output
    fetch(0);
    en = 1'b0;
    fetch(4);
    tick();
    chk("stall_instr", instr, 32'h2001_0002);
    chk("stall_inv", 32'(inv), 32'd0);
    en = 1'b1;
    tick();
    chk("unstall_instr", instr, 32'hFFFF_FFFF);

    // Valid bytes in DONE are ignored
    lvalid = 1'b1; lbyte = 8'hAA;
    tick(); tick();
    lvalid = 1'b0;
    chk("done_ign_count", 32'(lcount), 32'd2);
    chk("done_ign_done", 32'(ldone), 32'd1);

    // Load with gaps in valid, fetch attempted throughout
    pc = 0;
    pulse_start();
    send_byte(8'h12);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_instr", instr, 32'h0);
    tick(); tick();
    send_byte(8'h34); tick();
    send_byte(8'h56); tick(); tick(); tick();
    send_byte(8'h78);
    chk("gap_write_busy", 32'(busy), 32'd1);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("gap_count", 32'(lcount), 32'd2);
    fetch(0); chk("gap_pc0", instr, 32'h1234_5678);

    // Fill the whole array with non-HALT words
    pulse_start();
    for (int i = 0; i < CELDAS; i++) send_word(32'hA000_0000 + 32'(i));
    wait_done();
    chk("full_count", 32'(lcount), 32'(CELDAS));
    fetch(4 * CELDAS - 4); chk("full_last", instr, 32'hA000_000F);
    fetch(0);              chk("full_first", instr, 32'hA000_0000);

    // Reset in the middle of word 1
    pulse_start();
    send_word(32'h1122_3344);
    send_byte(8'h55);
    send_byte(8'h66);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(lready), 32'd0);
    chk("midrst_done", 32'(ldone), 32'd0);
    chk("midrst_count", 32'(lcount), 32'd0);
    rst_n = 1'b1;
    tick();
    fetch(0); chk("midrst_pc0", instr, 32'h1122_3344);
    fetch(4); chk("midrst_pc4", instr, 32'hA000_0001);

    // Valid bytes in IDLE are ignored
    lvalid = 1'b1; lbyte = 8'h77;
    tick();
    lvalid = 1'b0;
    chk("idle_ign_busy", 32'(busy), 32'd0);
    chk("idle_ign_count", 32'(lcount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
